// File: rtl/adv_pkg.sv
// Shared definitions for the adventure room controller.
//   room_t     : room encoding, 3 bits, codes 0..6 used, 7 unreachable
//   SEG_TABLE  : active-low seven-segment pattern per room code
//                (bit 6 = segment a ... bit 0 = segment g)
//   DIR_*      : bit positions of the four direction buttons in a press vector
//   one_hot4() : true when exactly one of four bits is set
package adv_pkg;

  typedef enum logic [2:0] {
    CAVE   = 3'd0,
    TUNNEL = 3'd1,
    RIVER  = 3'd2,
    STASH  = 3'd3,
    DEN    = 3'd4,
    VAULT  = 3'd5,
    GRAVE  = 3'd6
  } room_t;

  // Code 7 never appears in normal operation; it shows a blank display.
  localparam logic [6:0] SEG_TABLE [8] = '{
    7'b0000001,  // 0 CAVE
    7'b1001111,  // 1 TUNNEL
    7'b0010010,  // 2 RIVER
    7'b0000110,  // 3 STASH
    7'b1001100,  // 4 DEN
    7'b0100100,  // 5 VAULT
    7'b0100000,  // 6 GRAVE
    7'b1111111   // 7 unused
  };

  localparam int DIR_N = 3;
  localparam int DIR_S = 2;
  localparam int DIR_E = 1;
  localparam int DIR_W = 0;

  function automatic logic one_hot4(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge (press) detector for the four direction buttons.
//   clk   : system clock
//   reset : synchronous active-high reset, clears the held-level register
//   btn   : button levels {n, s, e, w}, already synchronised
//   press : one-cycle pulse per bit where the level went 0 -> 1
// Because btn_q is cleared by reset, a button already held when reset is
// released registers as a press at the first edge after release.
module btn_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] press
);

  logic [3:0] btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 4'd0;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/room_fsm.sv
// Room navigation state machine for the adventure game.
//   clk          : system clock, all state on rising edge
//   reset        : synchronous active-high reset (room=CAVE, moves=0)
//   btn_n/s/e/w  : direction button levels
//   v            : sword-held flag, decides DEN exit (VAULT or GRAVE)
//   sw           : 1 while in STASH
//   room         : current room code
//   win / dead   : 1 in VAULT / GRAVE
//   moves        : saturating count of button moves that changed room
//   LED_out      : active-low seven-segment pattern of the current room
// All outputs decode the registered room only; no input reaches them
// combinationally.
module room_fsm
  import adv_pkg::*;
#(
  parameter int MOVE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_n,
  input  logic              btn_s,
  input  logic              btn_e,
  input  logic              btn_w,
  input  logic              v,
  output logic              sw,
  output logic [2:0]        room,
  output logic              win,
  output logic              dead,
  output logic [MOVE_W-1:0] moves,
  output logic [6:0]        LED_out
);

  logic [3:0] press;
  logic       single;
  room_t      room_q;
  room_t      target;
  logic       moved;

  function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] m);
    return (&m) ? m : m + MOVE_W'(1);
  endfunction

  btn_edge u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .btn   ({btn_n, btn_s, btn_e, btn_w}),
    .press (press)
  );

  // Only a lone press is a move; chords are dropped entirely.
  assign single = one_hot4(press);

  // Button-driven destination; equals the current room when nothing applies.
  always_comb begin
    target = room_q;
    if (single) begin
      unique case (room_q)
        CAVE:    if (press[DIR_E]) target = TUNNEL;
        TUNNEL: begin
          if (press[DIR_W]) target = CAVE;
          if (press[DIR_S]) target = RIVER;
        end
        RIVER: begin
          if (press[DIR_W]) target = TUNNEL;
          if (press[DIR_N]) target = STASH;
          if (press[DIR_E]) target = DEN;
        end
        STASH:   if (press[DIR_W]) target = RIVER;
        default: target = room_q;
      endcase
    end
  end

  assign moved = (target != room_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      room_q <= CAVE;
      moves  <= '0;
    end else begin
      case (room_q)
        // DEN is left unconditionally; the exit is not a counted move.
        DEN:   room_q <= v ? VAULT : GRAVE;
        VAULT: room_q <= VAULT;
        GRAVE: room_q <= GRAVE;
        CAVE, TUNNEL, RIVER, STASH: begin
          if (moved) begin
            room_q <= target;
            moves  <= sat_inc(moves);
          end
        end
        default: room_q <= CAVE;
      endcase
    end
  end

  assign room    = room_q;
  assign sw      = (room_q == STASH);
  assign win     = (room_q == VAULT);
  assign dead    = (room_q == GRAVE);
  assign LED_out = SEG_TABLE[room_q];

endmodule

// File: tb/tb_room_fsm.sv
// Directed bench for room_fsm: reset behaviour, win and death paths,
// chorded/held buttons, move saturation and reset during the DEN exit.
module tb_room_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btns;   // {n, s, e, w}
  logic       v;
  logic       sw, win, dead;
  logic [2:0] room;
  logic [7:0] moves;
  logic [6:0] led;

  logic       reset2;
  logic [3:0] btns2;
  logic       sw2, win2, dead2;
  logic [2:0] room2;
  logic [1:0] moves2;
  logic [6:0] led2;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] BN = 4'b1000;
  localparam logic [3:0] BS = 4'b0100;
  localparam logic [3:0] BE = 4'b0010;
  localparam logic [3:0] BW = 4'b0001;

  always #5 clk = ~clk;

  room_fsm #(.MOVE_W(8)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btns[3]), .btn_s(btns[2]), .btn_e(btns[1]), .btn_w(btns[0]),
    .v(v), .sw(sw), .room(room), .win(win), .dead(dead),
    .moves(moves), .LED_out(led)
  );

  room_fsm #(.MOVE_W(2)) dut_sat (
    .clk(clk), .reset(reset2),
    .btn_n(btns2[3]), .btn_s(btns2[2]), .btn_e(btns2[1]), .btn_w(btns2[0]),
    .v(1'b0), .sw(sw2), .room(room2), .win(win2), .dead(dead2),
    .moves(moves2), .LED_out(led2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press and release one button on the main DUT (two edges).
  task automatic pulse(input logic [3:0] b);
    btns = b;
    step();
    btns = 4'd0;
    step();
  endtask

  task automatic pulse2(input logic [3:0] b);
    btns2 = b;
    step();
    btns2 = 4'd0;
    step();
  endtask

  task automatic do_reset();
    btns  = 4'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    reset2 = 1'b1;
    btns   = 4'd0;
    btns2  = 4'd0;
    v      = 1'b0;
    #2;

    // Reset held two cycles with east held
    btns = BE;
    step();
    step();
    check("rst_room", room, 0);
    check("rst_moves", moves, 0);
    check("rst_led", led, 7'b0000001);
    check("rst_flags", {sw, win, dead}, 0);
    reset  = 1'b0;
    reset2 = 1'b0;
    step();
    check("rel_room", room, 1);
    check("rel_moves", moves, 1);
    check("rel_led", led, 7'b1001111);
    btns = 4'd0;
    step();

    // Win path
    do_reset();
    pulse(BE);
    pulse(BS);
    pulse(BN);
    check("stash_room", room, 3);
    check("stash_sw", sw, 1);
    check("stash_led", led, 7'b0000110);
    pulse(BW);
    check("back_river", room, 2);
    v    = 1'b1;
    btns = BE;
    step();
    check("den_room", room, 4);
    check("den_led", led, 7'b1001100);
    check("den_sw", sw, 0);
    btns = 4'd0;
    step();
    check("vault_room", room, 5);
    check("vault_win", win, 1);
    check("vault_moves", moves, 5);
    check("vault_led", led, 7'b0100100);
    pulse(BN);
    pulse(BW);
    check("vault_hold", room, 5);
    check("vault_moves2", moves, 5);

    // Death path
    v = 1'b0;
    do_reset();
    pulse(BE);
    pulse(BS);
    btns = BE;
    step();
    check("den2_room", room, 4);
    btns = 4'd0;
    step();
    check("grave_room", room, 6);
    check("grave_dead", dead, 1);
    check("grave_win", win, 0);
    check("grave_led", led, 7'b0100000);
    pulse(BN);
    pulse(BW);
    pulse(BE);
    check("grave_hold", room, 6);
    check("grave_moves", moves, 3);

    // Simultaneous presses and a long hold
    do_reset();
    pulse(BE);
    pulse(BS);
    check("chord_pre", room, 2);
    btns = BN | BE;
    step();
    check("chord_room", room, 2);
    check("chord_moves", moves, 2);
    step();
    check("chord_held", room, 2);
    btns = 4'd0;
    step();
    btns = BW;
    for (int i = 0; i < 10; i++) step();
    check("hold_room", room, 1);
    check("hold_moves", moves, 3);
    btns = 4'd0;
    step();

    // Saturation on the 2-bit counter
    pulse2(BE);
    pulse2(BW);
    pulse2(BE);
    check("sat_moves3", moves2, 3);
    pulse2(BW);
    pulse2(BE);
    check("sat_room", room2, 1);
    check("sat_moves", moves2, 3);

    // Reset coinciding with the DEN exit
    do_reset();
    v = 1'b1;
    pulse(BE);
    pulse(BS);
    btns = BE;
    step();
    check("mid_den", room, 4);
    btns  = 4'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_room", room, 0);
    check("mid_flags", {win, dead}, 0);
    check("mid_moves", moves, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
